// File: rtl/sync_fifo_param_pkg.sv
// Shared sizing helpers for the parameterised synchronous FIFO and its storage array.
package sync_fifo_param_pkg;

    // Pointer width for a power-of-two depth; occupancy needs one extra bit to reach DEPTH.
    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module fifo_ram_dp
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are intentionally left uninitialised; reset only clears the pointers.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with programmable almost flags, error pulses and selectable registered/FWFT output.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0,
    localparam int AW       = addr_w(DEPTH),
    localparam int CW       = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     fifo_count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              rd_acc;
    logic              wr_acc;
    logic [DATA_W-1:0] rdata;

    // Flags decode the registered count only, so they never see the inputs combinationally.
    assign empty        = (count == '0);
    assign full         = (count == FULL_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign fifo_count   = count;

    // A full FIFO still accepts a write when the same cycle pops an entry.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    fifo_ram_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is exposed directly; zero while there is nothing to show.
            assign data_out = empty ? '0 : rdata;
        end else begin : g_reg
            logic [DATA_W-1:0] data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= rdata;
                end
            end

            assign data_out = data_q;
        end
    endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised successor to the team's fixed 8x8 synchronous FIFO.
- Single-clock FIFO with configurable data width and depth, programmable almost-full and almost-empty thresholds, and one-cycle overflow/underflow error pulses.
- Selectable output mode: registered read (standard) or first-word-fall-through (FWFT).
- Sits between producer and consumer blocks in the same clock domain as a general buffering primitive.

Parameters:
- DATA_W, 8: data width in bits, >=1.
- DEPTH, 8: number of entries; power of two, >=2.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- data_in  in  DATA_W  write data.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge of the head entry).
- data_out  out  DATA_W  read data.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

Behaviour:
- Derived widths: AW = $clog2(DEPTH); CW = AW+1.
- State: wr_ptr and rd_ptr (AW bits each, wrap naturally modulo DEPTH); count register (CW bits).
- Reset, sampled on the clk edge with rst=1:
  - wr_ptr, rd_ptr, count = 0; data_out = 0; overflow = underflow = 0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full = (AF_THRESH==0 ? 1 : 0).
  - Memory contents are not cleared.
  - Reset mid-operation discards all entries; rst has priority over wr_en and rd_en in the same cycle.
- Acceptance rules, evaluated on pre-edge state:
  - rd_acc = rd_en & !empty.
  - wr_acc = wr_en & (!full | rd_acc). A write into a full FIFO succeeds if a read is accepted in the same cycle.
  - Empty with wr_en=1 and rd_en=1: the write is accepted, the read is rejected, and underflow pulses. This holds in both modes.
- Updates on an accepted write: mem[wr_ptr] <= data_in; wr_ptr increments.
- Updates on an accepted read: rd_ptr increments.
- Count update:
  - +1 when wr_acc and not rd_acc.
  - -1 when rd_acc and not wr_acc.
  - Unchanged when both are accepted or neither is.
- Flags: all flags are pure decodes of the count register, so they change in the cycle after the causing edge. No combinational path from the inputs to any flag.
- Error pulses (registered; high for exactly one cycle after the offending edge):
  - overflow <= wr_en & !wr_acc.
  - underflow <= rd_en & !rd_acc.
- FWFT=0 (registered read):
  - On rd_acc, data_out <= mem[rd_ptr]; data is valid the cycle after rd_en (1-cycle latency).
  - data_out holds its value when there is no accepted read, including on underflow.
- FWFT=1 (first-word-fall-through):
  - data_out = mem[rd_ptr] whenever !empty; data_out = 0 when empty.
  - The first word written appears on data_out one cycle after the write edge, together with empty deasserting.
  - rd_en pops the head entry; the next entry is visible the following cycle.
- Pointer wrap: after DEPTH accepted writes, wr_ptr returns to 0. Ordering is preserved across the wrap.
- Invariant: count == wr_ptr - rd_ptr (mod DEPTH), except when count == DEPTH, where the pointers are equal.

Decomposition:
- No shared package required; AW and CW are local parameters computed from DEPTH.
- One natural sub-module: fifo_ram_dp, a DEPTH x DATA_W register array with:
  - one synchronous write port (we, waddr, wdata);
  - one asynchronous read port (raddr, rdata).
- The top level holds the pointers, count, flags, error pulses, and the FWFT/registered output mux, selected by a generate on FWFT.

Test Plan (DEPTH=8, DATA_W=8, AF_THRESH=6, AE_THRESH=2 unless noted):
- Reset then idle -> empty=1, almost_empty=1, full=0, almost_full=0, fifo_count=0, data_out=8'h00, overflow=underflow=0.
- Write 8'h11..8'h88 (8 writes) -> almost_empty drops after the 3rd write, almost_full rises after the 6th, full=1 and fifo_count=8 after the 8th. A 9th write of 8'h99 -> overflow pulses once and fifo_count stays 8.
- From full, 8 reads with FWFT=0 -> data_out = 8'h11..8'h88, each one cycle after its rd_en. Then empty=1. A further read -> underflow pulses, data_out holds 8'h88.
- Full FIFO, wr_en=rd_en=1 with data_in=8'hAA -> head popped, no overflow, fifo_count stays 8. 8'hAA is read out last.
- Write and read 20 words interleaved (crosses the pointer wrap twice) -> output order matches input exactly, fifo_count never exceeds 8.
- FWFT=1: write 8'h5A into an empty FIFO -> the next cycle empty=0 and data_out=8'h5A with no rd_en. rd_en then pops it -> empty=1, data_out=0. Assert rst with 3 entries queued -> fifo_count=0 and empty=1 on the next cycle.
